// File: rtl/enc_in_window.sv
`default_nettype none
// ============================================================================
// Module      : enc_in_window
// Description : Sliding-window sample framer for an ECG encoder; optional
//               baseline removal when WINDOW_BASELINE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module enc_in_window #(
  parameter int BITSIZE  = 16,
  parameter int N        = 10,
  parameter int STRIDE   = 5,
  parameter int BL_SHIFT = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [BITSIZE-1:0]     s_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [BITSIZE*N-1:0]   m_data,
  output logic [15:0]            frame_cnt
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] SLIDE_LAST = CNT_W'(STRIDE - 1);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    HOLD  = 2'd1,
    SLIDE = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [N-1:0][BITSIZE-1:0] win_q, win_d;
  logic [15:0]               frame_cnt_q, frame_cnt_d;
  logic [BITSIZE-1:0]        sample_w;
  logic                      s_xfer;
  logic                      m_xfer;

  if (N < 1 || STRIDE < 1 || STRIDE > N || BL_SHIFT < 0) begin : g_cfg_check
    $error("enc_in_window: illegal parameter combination");
  end

  // Handshake flags depend on state only, so no combinational ready/valid loop.
  assign s_ready   = (state_q != HOLD);
  assign m_valid   = (state_q == HOLD);
  assign s_xfer    = s_valid && s_ready;
  assign m_xfer    = m_valid && m_ready;
  assign m_data    = win_q;
  assign frame_cnt = frame_cnt_q;

`ifdef WINDOW_BASELINE_EN
  logic signed [BITSIZE-1:0] baseline_q, baseline_d;
  logic signed [BITSIZE:0]   diff;

  always_comb begin
    diff       = {s_data[BITSIZE-1], s_data} - {baseline_q[BITSIZE-1], baseline_q};
    baseline_d = baseline_q;
    if (diff[BITSIZE] != diff[BITSIZE-1]) begin
      sample_w = diff[BITSIZE] ? {1'b1, {(BITSIZE-1){1'b0}}}
                               : {1'b0, {(BITSIZE-1){1'b1}}};
    end else begin
      sample_w = diff[BITSIZE-1:0];
    end
    // Baseline tracks only samples that are actually stored.
    if (s_xfer && !clear) begin
      baseline_d = baseline_q + BITSIZE'(diff >>> BL_SHIFT);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baseline_q <= '0;
    end else begin
      baseline_q <= baseline_d;
    end
  end
`else
  assign sample_w = s_data;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    win_d       = win_q;
    frame_cnt_d = frame_cnt_q;

    if (s_xfer) begin
      for (int k = 0; k < N - 1; k++) begin
        win_d[k] = win_q[k+1];
      end
      win_d[N-1] = sample_w;
      cnt_d      = cnt_q + CNT_W'(1);
    end

    case (state_q)
      FILL: begin
        if (s_xfer && (cnt_q == FILL_LAST)) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      SLIDE: begin
        if (s_xfer && (cnt_q == SLIDE_LAST)) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (m_xfer) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = SLIDE;
        end
      end
      default: begin
        state_d = FILL;
        cnt_d   = '0;
      end
    endcase

    // Restart wins over any transfer in the same cycle; window data is kept.
    if (clear) begin
      state_d     = FILL;
      cnt_d       = '0;
      win_d       = win_q;
      frame_cnt_d = frame_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      win_q       <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      win_q       <= win_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_enc_in_window.sv
`default_nettype none
// ============================================================================
// Module      : tb_enc_in_window
// Description : Scoreboard bench for enc_in_window (STRIDE 5 and 10 instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_enc_in_window;

  localparam int BITSIZE = 16;
  localparam int N       = 10;
  localparam int W       = BITSIZE * N;
  localparam int BLS     = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic               clear     [2];
  logic               s_valid   [2];
  logic               s_ready   [2];
  logic [BITSIZE-1:0] s_data    [2];
  logic               m_valid   [2];
  logic               m_ready   [2];
  logic [W-1:0]       m_data    [2];
  logic [15:0]        frame_cnt [2];

  enc_in_window #(.BITSIZE(BITSIZE), .N(N), .STRIDE(5), .BL_SHIFT(BLS)) dut (
    .clk(clk), .reset(reset), .clear(clear[0]),
    .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_data(s_data[0]),
    .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_data(m_data[0]),
    .frame_cnt(frame_cnt[0])
  );

  enc_in_window #(.BITSIZE(BITSIZE), .N(N), .STRIDE(10), .BL_SHIFT(BLS)) dut_s10 (
    .clk(clk), .reset(reset), .clear(clear[1]),
    .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_data(s_data[1]),
    .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_data(m_data[1]),
    .frame_cnt(frame_cnt[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: window contents, count toward next window, threshold.
  logic [W-1:0]       mwin [2];
  int                 mcnt [2];
  int                 mthr [2];
  logic [15:0]        mbl  [2];
  logic [W-1:0]       q0 [$];
  logic [W-1:0]       q1 [$];

  function automatic int stride_of(input int id);
    return (id == 0) ? 5 : 10;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mwin[i] = '0;
      mcnt[i] = 0;
      mthr[i] = N;
      mbl[i]  = '0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic model_clear(input int id);
    mcnt[id] = 0;
    mthr[id] = N;
  endtask

  task automatic model_accept(input int id, input logic [15:0] d, output bit done);
    logic [15:0] st;
`ifdef WINDOW_BASELINE_EN
    int di;
    int bl;
    bl = $signed(mbl[id]);
    di = $signed(d) - bl;
    if (di > 32767)       st = 16'h7FFF;
    else if (di < -32768) st = 16'h8000;
    else                  st = di[15:0];
    mbl[id] = 16'(bl + (di >>> BLS));
`else
    st = d;
`endif
    mwin[id] = {st, mwin[id][W-1:BITSIZE]};
    mcnt[id]++;
    done = 1'b0;
    if (mcnt[id] == mthr[id]) begin
      if (id == 0) q0.push_back(mwin[id]);
      else         q1.push_back(mwin[id]);
      mcnt[id] = 0;
      mthr[id] = stride_of(id);
      done     = 1'b1;
    end
  endtask

  // Compare each window when m_valid rises.
  logic prev_mv [2] = '{1'b0, 1'b0};
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (m_valid[i] && !prev_mv[i]) begin
        if (i == 0) begin
          if (q0.size() == 0) check_eq("win0_unexpected", 1, 0);
          else check_eq("win0_data", m_data[0], q0.pop_front());
        end else begin
          if (q1.size() == 0) check_eq("win1_unexpected", 1, 0);
          else check_eq("win1_data", m_data[1], q1.pop_front());
        end
      end
      prev_mv[i] = m_valid[i];
    end
  end

  task automatic send(input int id, input logic [15:0] d);
    int t;
    bit done;
    t = 0;
    @(negedge clk);
    s_valid[id] = 1'b1;
    s_data[id]  = d;
    while (!s_ready[id] && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      check_eq("send_timeout", 0, 1);
      s_valid[id] = 1'b0;
      return;
    end
    @(posedge clk);
    model_accept(id, d, done);
    if (done) begin
      @(negedge clk);
      check_eq("mvalid_latency", m_valid[id], 1);
      check_eq("sready_in_hold", s_ready[id], 0);
    end
  endtask

  task automatic idle(input int id, input int n);
    @(negedge clk);
    s_valid[id] = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_no_window(input int id);
    @(negedge clk);
    s_valid[id] = 1'b0;
    check_eq("no_early_window", m_valid[id], 0);
  endtask

  task automatic pulse_ready(input int id, input logic [15:0] exp_fc);
    @(negedge clk);
    s_valid[id] = 1'b0;
    m_ready[id] = 1'b1;
    @(negedge clk);
    m_ready[id] = 1'b0;
    check_eq("frame_cnt_after_hs", frame_cnt[id], exp_fc);
    check_eq("mvalid_after_hs", m_valid[id], 0);
  endtask

  task automatic clear_with_sample(input int id, input logic [15:0] d);
    @(negedge clk);
    s_valid[id] = 1'b1;
    s_data[id]  = d;
    clear[id]   = 1'b1;
    @(posedge clk);
    model_clear(id);
    @(negedge clk);
    clear[id]   = 1'b0;
    s_valid[id] = 1'b0;
    check_eq("clear_sready", s_ready[id], 1);
    check_eq("clear_mvalid", m_valid[id], 0);
  endtask

  task automatic clear_in_hold(input int id, input logic [15:0] exp_fc);
    @(negedge clk);
    s_valid[id] = 1'b0;
    clear[id]   = 1'b1;
    m_ready[id] = 1'b1;
    @(negedge clk);
    clear[id]   = 1'b0;
    m_ready[id] = 1'b0;
    model_clear(id);
    check_eq("clr_hold_mvalid", m_valid[id], 0);
    check_eq("clr_hold_sready", s_ready[id], 1);
    check_eq("clr_hold_frame_cnt", frame_cnt[id], exp_fc);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_valid[i] = 1'b0;
      clear[i]   = 1'b0;
      m_ready[i] = 1'b0;
    end
    model_reset();
    #2;
    for (int i = 0; i < 2; i++) begin
      check_eq("rst_sready", s_ready[i], 1);
      check_eq("rst_mvalid", m_valid[i], 0);
      check_eq("rst_mdata", m_data[i], 0);
      check_eq("rst_frame_cnt", frame_cnt[i], 0);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      clear[i] = 1'b0; s_valid[i] = 1'b0; s_data[i] = '0; m_ready[i] = 1'b0;
    end
    model_reset();

    // First window, held with m_ready low, then one slide of STRIDE samples.
    apply_reset();
    for (int v = 1; v <= 10; v++) send(0, 16'(v));
    idle(0, 3);
    check_eq("hold_mvalid_stable", m_valid[0], 1);
    check_eq("hold_sready_low", s_ready[0], 0);
    pulse_ready(0, 16'd1);
    for (int v = 11; v <= 15; v++) send(0, 16'(v));
    check_eq("frame_cnt_before_2nd_hs", frame_cnt[0], 1);
    pulse_ready(0, 16'd2);

    // Clear together with the 7th sample drops it and restarts the fill.
    apply_reset();
    for (int v = 1; v <= 6; v++) send(0, 16'(v));
    clear_with_sample(0, 16'd7);
    for (int v = 8; v <= 16; v++) send(0, 16'(v));
    check_no_window(0);
    send(0, 16'd17);
    clear_in_hold(0, 16'd0);
    for (int v = 100; v <= 109; v++) send(0, 16'(v));
    pulse_ready(0, 16'd1);
    for (int v = 110; v <= 114; v++) send(0, 16'(v));

    // Asynchronous reset while holding a window.
    @(negedge clk);
    s_valid[0] = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_eq("async_rst_mvalid", m_valid[0], 0);
    check_eq("async_rst_mdata", m_data[0], 0);
    check_eq("async_rst_frame_cnt", frame_cnt[0], 0);
    check_eq("async_rst_sready", s_ready[0], 1);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // Reset mid-window discards the partial window.
    for (int v = 200; v <= 202; v++) send(0, 16'(v));
    apply_reset();
    for (int v = 300; v <= 308; v++) send(0, 16'(v));
    check_no_window(0);
    send(0, 16'd309);
    pulse_ready(0, 16'd1);

`ifdef WINDOW_BASELINE_EN
    apply_reset();
    m_ready[0] = 1'b1;
    for (int v = 0; v < 12; v++) send(0, 16'h8000);
    for (int v = 0; v < 10; v++) send(0, 16'h7FFF);
    idle(0, 3);
    m_ready[0] = 1'b0;
`endif

    // Disjoint windows with s_valid and m_ready held high.
    m_ready[1] = 1'b1;
    for (int v = 1; v <= 20; v++) send(1, 16'(v));
    idle(1, 3);
    check_eq("s10_frame_cnt", frame_cnt[1], 2);
    m_ready[1] = 1'b0;

    idle(0, 2);
    check_eq("q0_drained", q0.size(), 0);
    check_eq("q1_drained", q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/enc_in_window.md
ENC_IN_WINDOW -- requirements
Module: enc_in_window

Interface
REQ-001 SHALL have parameter BITSIZE, default 16, sample width in bits (signed two's-complement fixed point).
REQ-002 SHALL have parameter N, default 10, window length in samples.
REQ-003 SHALL have parameter STRIDE, default 5, new samples per window after the first; legal range 1..N.
REQ-004 SHALL have parameter BL_SHIFT, default 6, baseline filter shift (used only with WINDOW_BASELINE_EN).
REQ-005 clk  input  1  clock, rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 clear  input  1  synchronous restart of window fill.
REQ-008 s_valid  input  1  upstream sample valid.
REQ-009 s_ready  output  1  block accepts a sample this cycle.
REQ-010 s_data  input  BITSIZE  ECG sample.
REQ-011 m_valid  output  1  window available.
REQ-012 m_ready  input  1  downstream encoder accepts the window.
REQ-013 m_data  output  BITSIZE*N  window vector; element k at bits [BITSIZE*k +: BITSIZE], element 0 oldest, N-1 newest.
REQ-014 frame_cnt  output  16  number of windows accepted downstream, wraps 0xFFFF->0.

Function
REQ-015 Sample transfer SHALL occur on a rising edge with s_valid && s_ready; window transfer on m_valid && m_ready.
REQ-016 FSM states SHALL be FILL, HOLD, SLIDE.
REQ-017 FILL: s_ready=1, m_valid=0; each transfer shifts the window (element k <= element k+1, element N-1 <= sample) and increments cnt; at cnt==N-1 with transfer, next state HOLD, cnt<=0.
REQ-018 HOLD: s_ready=0, m_valid=1, m_data stable; on m_ready, frame_cnt increments, next state SLIDE (or HOLD again next cycle unchanged if m_ready low).
REQ-019 SLIDE: s_ready=1, m_valid=0; transfers shift as in FILL; at cnt==STRIDE-1 with transfer, next state HOLD, cnt<=0.
REQ-020 Consecutive windows SHALL therefore overlap by N-STRIDE samples; STRIDE==N gives disjoint windows.
REQ-021 m_valid SHALL assert the cycle after the completing sample transfer (one-cycle latency).
REQ-022 clear SHALL force state FILL, cnt<=0, window contents unchanged, frame_cnt unchanged; clear has priority over any simultaneous sample or window transfer, which are discarded (no frame_cnt increment).
REQ-023 s_valid low in FILL/SLIDE SHALL hold all state; m_valid SHALL NOT drop in HOLD until handshake or clear.
REQ-024 s_ready and m_valid SHALL be decoded from state only (no combinational path from s_valid or m_ready).

Reset
REQ-025 reset SHALL set state FILL, cnt 0, all window elements 0, frame_cnt 0, baseline 0; hence s_ready=1, m_valid=0, m_data=0 during reset.
REQ-026 reset asserted mid-window SHALL discard the partial window; the first window after release needs N fresh samples.

Configuration
REQ-027 Macro WINDOW_BASELINE_EN defined: each accepted sample SHALL be stored as sat(s_data - baseline) with baseline updated on the same edge to baseline + ((s_data - baseline) >>> BL_SHIFT), arithmetic on BITSIZE+1 bits, stored value saturated to signed BITSIZE range; clear does not reset baseline.
REQ-028 Macro not defined: s_data SHALL be stored unmodified and no baseline register exists.

Verification
REQ-029 Reset, then feed samples 1..10 with s_valid=1, m_ready=0 -> m_valid=1 on cycle after 10th, s_ready=0, m_data elements 0..9 = 1..10.
REQ-030 From REQ-029 state pulse m_ready=1, feed 11..15 -> second window elements = 6..15, frame_cnt=1 after first handshake.
REQ-031 STRIDE=10, feed 1..20 with m_ready=1 -> windows 1..10 and 11..20, frame_cnt=2, no sample dropped while s_valid held high.
REQ-032 clear asserted together with 7th sample -> sample dropped, state FILL, next window completes after 10 more samples.
REQ-033 reset asserted in HOLD -> m_valid=0, m_data=0, frame_cnt=0 immediately (asynchronous).
REQ-034 WINDOW_BASELINE_EN, BL_SHIFT=1, constant input 0x7FFF after baseline 0x8000 forced via sample sequence -> stored values saturate to 0x7FFF, never wrap negative.
